// File: rtl/sync_mutex_merge_rr.sv
// ============================================================================
// Module   : sync_mutex_merge_rr
// Brief    : N-way round-robin mutex merge with payload. One token is
//            outstanding downstream at a time. Define MUTEX_MERGE_ERR_EN to
//            build the sticky protocol-violation flag on o_err.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_mutex_merge_rr #(
  parameter int CHANNELS = 9,
  parameter int DATA_W   = 32,
  parameter int ID_W     = $clog2(CHANNELS)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [CHANNELS-1:0]        i_drive,
  input  logic [CHANNELS*DATA_W-1:0] i_data,
  output logic [CHANNELS-1:0]        o_free,
  output logic                       o_driveNext,
  output logic [DATA_W-1:0]          o_dataNext,
  output logic [ID_W-1:0]            o_grantId,
  input  logic                       i_freeNext,
  output logic                       o_err
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_BUSY = 1'b1;

  localparam int                  c_SUM_W = ID_W + 1;
  localparam logic [CHANNELS-1:0] c_ONE   = CHANNELS'(1);

  logic [0:0]          r_state;
  logic [0:0]          w_state_nxt;
  logic [CHANNELS-1:0] r_pending;
  logic [CHANNELS-1:0] w_pending_nxt;
  logic [CHANNELS-1:0] w_set;
  logic [CHANNELS-1:0] w_clr;
  logic [DATA_W-1:0]   r_hold [CHANNELS];
  logic [ID_W-1:0]     r_ptr;
  logic [ID_W-1:0]     w_ptr_nxt;
  logic [ID_W-1:0]     w_sel;
  logic                w_any;
  logic                w_grant;
  logic                w_release;

  // Round-robin pick: first pending channel at or after r_ptr, wrapping.
  always_comb begin : p_select
    logic [c_SUM_W-1:0] v_idx;
    logic               v_found;
    w_sel   = '0;
    v_found = 1'b0;
    v_idx   = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      v_idx = {1'b0, r_ptr} + c_SUM_W'(i);
      if (v_idx >= c_SUM_W'(CHANNELS)) begin
        v_idx = v_idx - c_SUM_W'(CHANNELS);
      end
      if (!v_found && r_pending[v_idx[ID_W-1:0]]) begin
        v_found = 1'b1;
        w_sel   = v_idx[ID_W-1:0];
      end
    end
  end

  assign w_any = |r_pending;

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_any)      w_state_nxt = S_BUSY;
      S_BUSY:  if (i_freeNext) w_state_nxt = S_IDLE;
      default:                 w_state_nxt = S_IDLE;
    endcase
  end

  // FSM output decode: grant load in IDLE, release of the owner in BUSY
  always_comb begin
    w_grant   = 1'b0;
    w_release = 1'b0;
    case (r_state)
      S_IDLE:  w_grant   = w_any;
      S_BUSY:  w_release = i_freeNext;
      default: ;
    endcase
  end

  // A drive on an already-pending channel is dropped so its payload survives.
  assign w_set         = i_drive & ~r_pending;
  assign w_clr         = w_release ? (c_ONE << o_grantId) : '0;
  assign w_pending_nxt = (r_pending & ~w_clr) | w_set;
  assign w_ptr_nxt     = (o_grantId == ID_W'(CHANNELS - 1)) ? '0 : o_grantId + ID_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pending   <= '0;
      r_ptr       <= '0;
      o_driveNext <= 1'b0;
      o_dataNext  <= '0;
      o_grantId   <= '0;
      o_free      <= '0;
    end else begin
      r_pending   <= w_pending_nxt;
      o_driveNext <= w_grant;
      o_free      <= w_clr;
      if (w_grant) begin
        o_grantId  <= w_sel;
        o_dataNext <= r_hold[w_sel];
      end
      if (w_release) begin
        r_ptr <= w_ptr_nxt;
      end
    end
  end

  // Payload holding registers are qualified by the pending bits, no reset needed.
  always_ff @(posedge clk) begin
    for (int k = 0; k < CHANNELS; k++) begin
      if (w_set[k]) begin
        r_hold[k] <= i_data[k*DATA_W +: DATA_W];
      end
    end
  end

`ifdef MUTEX_MERGE_ERR_EN
  logic r_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if ((|(i_drive & r_pending)) ||
                 (i_freeNext && (r_state == S_IDLE)) ||
                 (i_freeNext && (|o_free))) begin
      r_err <= 1'b1;
    end
  end

  assign o_err = r_err;
`else
  assign o_err = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_sync_mutex_merge_rr.sv
// ============================================================================
// Module   : tb_sync_mutex_merge_rr
// Brief    : Directed self-checking bench for sync_mutex_merge_rr (9 x 32).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sync_mutex_merge_rr;

  localparam int CH = 9;
  localparam int DW = 32;
  localparam int IW = 4;
`ifdef MUTEX_MERGE_ERR_EN
  localparam logic c_ERR_EXP = 1'b1;
`else
  localparam logic c_ERR_EXP = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [CH-1:0]    i_drive = '0;
  logic [CH*DW-1:0] i_data = '0;
  logic [CH-1:0]    o_free;
  logic             o_driveNext;
  logic [DW-1:0]    o_dataNext;
  logic [IW-1:0]    o_grantId;
  logic             i_freeNext = 1'b0;
  logic             o_err;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int last_d  = 0;

  sync_mutex_merge_rr #(.CHANNELS(CH), .DATA_W(DW), .ID_W(IW)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_drive    (i_drive),
    .i_data     (i_data),
    .o_free     (o_free),
    .o_driveNext(o_driveNext),
    .o_dataNext (o_dataNext),
    .o_grantId  (o_grantId),
    .i_freeNext (i_freeNext),
    .o_err      (o_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One cycle: inputs set before the call are single-cycle pulses.
  task automatic step();
    @(posedge clk);
    #1;
    i_drive    = '0;
    i_freeNext = 1'b0;
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic set_data(input int k, input logic [DW-1:0] v);
    i_data[k*DW +: DW] = v;
  endtask

  function automatic logic [DW-1:0] pay(input int k);
    return 32'hD000_0000 + DW'(k);
  endfunction

  // Wait for the token, check it, free it one cycle later, check the free pulse.
  task automatic serve(input string tag, input int id, input logic [DW-1:0] dat,
                       input int gap, input logic [CH-1:0] redrive);
    int n;
    logic [CH-1:0] oh;
    n = 0;
    while (!o_driveNext && n < 20) begin
      step();
      n++;
    end
    check_eq({tag, "_drv"}, o_driveNext, 1'b1);
    if (gap > 0) check_eq({tag, "_gap"}, cyc - last_d, gap);
    last_d = cyc;
    check_eq({tag, "_id"}, o_grantId, id);
    check_eq({tag, "_data"}, o_dataNext, dat);
    step();
    i_freeNext = 1'b1;
    step();
    oh = CH'(1) << id;
    check_eq({tag, "_free"}, o_free, oh);
    i_drive = redrive;
  endtask

  initial begin
    for (int k = 0; k < CH; k++) set_data(k, pay(k));
    do_reset();
    check_eq("rst_free", o_free, 0);
    check_eq("rst_drv", o_driveNext, 0);
    check_eq("rst_data", o_dataNext, 0);
    check_eq("rst_id", o_grantId, 0);
    check_eq("rst_err", o_err, 0);

    // Single channel latency and free routing
    set_data(3, 32'hA5A5_0003);
    i_drive = 9'h008;
    last_d = cyc;
    step();
    check_eq("s1_c1_drv", o_driveNext, 0);
    serve("s1", 3, 32'hA5A5_0003, 2, '0);
    step();
    check_eq("s1_free_once", o_free, 0);
    set_data(3, pay(3));

    // All channels at once, downstream frees one cycle after each driveNext
    do_reset();
    i_drive = 9'h1FF;
    last_d = cyc;
    for (int g = 0; g < CH; g++) begin
      serve($sformatf("all%0d", g), g, pay(g), (g == 0) ? 2 : 3, '0);
    end
    step();
    step();
    check_eq("all_quiet", o_driveNext, 0);

    // Fairness wrap: ptr=8 after serving 7; 8 redrives on its free cycle
    do_reset();
    i_drive = 9'h080;
    serve("w7", 7, pay(7), 0, '0);
    i_drive = 9'h101;
    serve("w8", 8, pay(8), 0, 9'h100);
    serve("w0", 0, pay(0), 3, '0);
    serve("w8b", 8, pay(8), 3, '0);

    // Stability while downstream withholds the free
    do_reset();
    set_data(4, 32'h1234_5678);
    i_drive = 9'h010;
    step();
    step();
    check_eq("st_drv", o_driveNext, 1);
    for (int t = 0; t < 20; t++) begin
      for (int k = 0; k < CH; k++) set_data(k, $urandom);
      step();
      check_eq("st_nodrv", o_driveNext, 0);
      check_eq("st_data", o_dataNext, 32'h1234_5678);
      check_eq("st_id", o_grantId, 4);
    end
    for (int k = 0; k < CH; k++) set_data(k, pay(k));
    i_freeNext = 1'b1;
    step();
    check_eq("st_free", o_free, 9'h010);

    // Free while IDLE: ignored, flagged only when the checker is built
    do_reset();
    i_freeNext = 1'b1;
    step();
    check_eq("v_err", o_err, c_ERR_EXP);
    check_eq("v_nofree", o_free, 0);
    step();
    step();
    check_eq("v_err_sticky", o_err, c_ERR_EXP);
    check_eq("v_nodrv", o_driveNext, 0);

    // Asynchronous reset mid-BUSY with channel 5 still pending
    do_reset();
    i_drive = 9'h024;
    step();
    step();
    check_eq("r_drv", o_driveNext, 1);
    check_eq("r_id", o_grantId, 2);
    #3;
    rst = 1'b1;
    #1;
    check_eq("r_async_drv", o_driveNext, 0);
    check_eq("r_async_id", o_grantId, 0);
    check_eq("r_async_data", o_dataNext, 0);
    check_eq("r_async_free", o_free, 0);
    check_eq("r_async_err", o_err, 0);
    step();
    rst = 1'b0;
    i_drive = 9'h020;
    last_d = cyc;
    serve("r5", 5, pay(5), 2, '0);
    for (int t = 0; t < 6; t++) begin
      step();
      check_eq("r_nostale", o_driveNext, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
